// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-N buffered demultiplexer.
package demux_pkg;

  localparam int DROP_W = 16;

  // Smallest b such that (1 << b) >= value; gives the select width.
  function automatic int clog2(input int value);
    int result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_consume,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // A load wins over a same-edge consume so a full slot can be refilled
  // back-to-back; a consume alone leaves the stale data in place.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/demux_1ton_buffered.sv
// Routes one valid/ready stream into one of NUM_OUTPUTS holding slots;
// transfers to an out-of-range select are discarded and counted.
module demux_1ton_buffered
  import demux_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int NUM_OUTPUTS = 8,
  localparam int SEL_W       = clog2(NUM_OUTPUTS)
) (
  input  logic                         Clock,
  input  logic                         Resetn,
  input  logic [WIDTH-1:0]             In_Data,
  input  logic [SEL_W-1:0]             In_Select,
  input  logic                         In_Valid,
  output logic                         In_Ready,
  output logic [NUM_OUTPUTS*WIDTH-1:0] ConcatenatedOutputs,
  output logic [NUM_OUTPUTS-1:0]       Out_Valid,
  input  logic [NUM_OUTPUTS-1:0]       Out_Ready,
  output logic                         Err,
  output logic [DROP_W-1:0]            DropCount
);

  logic [NUM_OUTPUTS-1:0] w_hit;
  logic [NUM_OUTPUTS-1:0] w_load;
  logic [NUM_OUTPUTS-1:0] w_consume;
  logic                   w_in_range;
  logic                   w_accept;
  logic                   w_drop;
  logic                   r_err;
  logic [DROP_W-1:0]      r_drop_count;

  always_comb begin
    w_hit = '0;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      w_hit[k] = (In_Select == SEL_W'(k));
    end
  end

  // Handshake: a word moves on a rising edge where valid and ready are both
  // high (input side: In_Valid/In_Ready, channel k: Out_Valid[k]/Out_Ready[k]).
  // In_Ready depends only on the selected slot and its consumer, never on
  // In_Valid; an out-of-range select is always ready so it can be dropped.
  assign w_in_range = |w_hit;
  assign In_Ready   = !w_in_range || (|(w_hit & (~Out_Valid | Out_Ready)));
  assign w_accept   = In_Valid && In_Ready;
  assign w_load     = {NUM_OUTPUTS{w_accept}} & w_hit;
  assign w_consume  = Out_Valid & Out_Ready;
  assign w_drop     = w_accept && !w_in_range;

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .i_clk    (Clock),
      .i_rst_n  (Resetn),
      .i_load   (w_load[g]),
      .i_consume(w_consume[g]),
      .i_data   (In_Data),
      .o_data   (ConcatenatedOutputs[g*WIDTH +: WIDTH]),
      .o_valid  (Out_Valid[g])
    );
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_err        <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_err <= w_drop;
      if (w_drop && (r_drop_count != '1)) begin
        r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  assign Err       = r_err;
  assign DropCount = r_drop_count;

endmodule

// File: tb/tb_demux_1ton_buffered.sv
// Directed and randomized checks of the buffered demux at 8 and 6 channels.
module tb_demux_1ton_buffered;

  logic        Clock = 1'b0;
  logic        Resetn;

  logic [7:0]  d8_data;
  logic [2:0]  d8_sel;
  logic        d8_valid;
  logic        d8_in_ready;
  logic [63:0] d8_concat;
  logic [7:0]  d8_ov;
  logic [7:0]  d8_or;
  logic        d8_err;
  logic [15:0] d8_drop;

  logic [7:0]  d6_data;
  logic [2:0]  d6_sel;
  logic        d6_valid;
  logic        d6_in_ready;
  logic [47:0] d6_concat;
  logic [5:0]  d6_ov;
  logic [5:0]  d6_or;
  logic        d6_err;
  logic [15:0] d6_drop;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  // Reference model of the 6-channel instance: one word per channel.
  logic       m_valid [6];
  logic [7:0] m_data  [6];
  int         m_drop;
  logic       m_err;

  always #5 Clock = ~Clock;

  demux_1ton_buffered #(.WIDTH(8), .NUM_OUTPUTS(8)) u_dut8 (
    .Clock(Clock), .Resetn(Resetn), .In_Data(d8_data), .In_Select(d8_sel),
    .In_Valid(d8_valid), .In_Ready(d8_in_ready), .ConcatenatedOutputs(d8_concat),
    .Out_Valid(d8_ov), .Out_Ready(d8_or), .Err(d8_err), .DropCount(d8_drop)
  );

  demux_1ton_buffered #(.WIDTH(8), .NUM_OUTPUTS(6)) u_dut6 (
    .Clock(Clock), .Resetn(Resetn), .In_Data(d6_data), .In_Select(d6_sel),
    .In_Valid(d6_valid), .In_Ready(d6_in_ready), .ConcatenatedOutputs(d6_concat),
    .Out_Valid(d6_ov), .Out_Ready(d6_or), .Err(d6_err), .DropCount(d6_drop)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [7:0] ch8(input int k);
    return d8_concat[k*8 +: 8];
  endfunction

  function automatic logic [7:0] ch6(input int k);
    return d6_concat[k*8 +: 8];
  endfunction

  task automatic load8(input logic [2:0] sel, input logic [7:0] data);
    d8_sel   = sel;
    d8_data  = data;
    d8_valid = 1'b1;
    tick();
    d8_valid = 1'b0;
  endtask

  initial begin
    int sel;
    int need;
    logic exp_ready;
    logic acc;
    logic [5:0]  exp_ov;
    logic [47:0] exp_c;

    Resetn = 1'b0;
    d8_data = '0; d8_sel = '0; d8_valid = 1'b0; d8_or = '0;
    d6_data = '0; d6_sel = '0; d6_valid = 1'b0; d6_or = '0;
    repeat (3) tick();
    chk("rst_ov8", d8_ov, 8'h00);
    chk("rst_data8", d8_concat, 64'h0);
    chk("rst_err8", d8_err, 1'b0);
    chk("rst_drop8", d8_drop, 16'h0);
    chk("rst_ov6", d6_ov, 6'h00);
    chk("rst_drop6", d6_drop, 16'h0);
    chk("rst_ready8", d8_in_ready, 1'b1);
    Resetn = 1'b1;
    tick();

    // Basic route
    d8_sel = 3'd3; d8_data = 8'hA5; d8_valid = 1'b1;
    #1 chk("basic_ready", d8_in_ready, 1'b1);
    tick();
    d8_valid = 1'b0;
    chk("basic_ov", d8_ov, 8'b0000_1000);
    chk("basic_data", d8_concat, 64'h0000_0000_A500_0000);

    // Backpressure
    d8_sel = 3'd3; d8_data = 8'h5A; d8_valid = 1'b1;
    #1 chk("bp_ready_low", d8_in_ready, 1'b0);
    tick();
    chk("bp_hold_data", ch8(3), 8'hA5);
    chk("bp_hold_ov", d8_ov, 8'b0000_1000);
    d8_or = 8'b0000_1000;
    #1 chk("bp_ready_high", d8_in_ready, 1'b1);
    tick();
    d8_valid = 1'b0; d8_or = '0;
    chk("bp_refill_ov", d8_ov, 8'b0000_1000);
    chk("bp_refill_data", ch8(3), 8'h5A);
    d8_or = 8'b0000_1000;
    tick();
    d8_or = '0;
    chk("bp_drain_ov", d8_ov, 8'h00);
    chk("bp_stale_data", ch8(3), 8'h5A);

    // Streaming
    d8_or = 8'b0000_0010;
    for (int i = 0; i < 16; i++) begin
      d8_sel = 3'd1; d8_data = 8'(i); d8_valid = 1'b1;
      exp_q.push_back(8'(i));
      #1 chk("stream_ready", d8_in_ready, 1'b1);
      tick();
      chk("stream_ov", d8_ov, 8'b0000_0010);
      chk("stream_data", ch8(1), exp_q.pop_front());
    end
    d8_valid = 1'b0;
    tick();
    d8_or = '0;
    chk("stream_end_ov", d8_ov, 8'h00);

    // Isolation
    load8(3'd2, 8'h22);
    d8_sel = 3'd6; d8_data = 8'h11; d8_valid = 1'b1;
    #1 chk("iso_ready", d8_in_ready, 1'b1);
    tick();
    d8_valid = 1'b0;
    chk("iso_ov", d8_ov, 8'b0100_0100);
    chk("iso_ch2", ch8(2), 8'h22);
    chk("iso_ch6", ch8(6), 8'h11);
    d8_or = 8'hFF;
    tick();
    d8_or = '0;
    chk("iso_drain", d8_ov, 8'h00);

    // Out-of-range on the 6-channel instance
    d6_sel = 3'd2; d6_data = 8'h33; d6_valid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      d6_sel = 3'd7; d6_data = 8'($urandom); d6_valid = 1'b1;
      #1 chk("oor_ready", d6_in_ready, 1'b1);
      tick();
      d6_valid = 1'b0;
      chk("oor_err_pulse", d6_err, 1'b1);
      chk("oor_ov", d6_ov, 6'b00_0100);
      tick();
      chk("oor_err_clear", d6_err, 1'b0);
    end
    chk("oor_drop", d6_drop, 16'd3);
    chk("oor_ch2", ch6(2), 8'h33);
    chk("pow2_drop8", d8_drop, 16'h0);

    // Reset mid-operation
    load8(3'd0, 8'h10);
    load8(3'd4, 8'h14);
    load8(3'd7, 8'h17);
    chk("mid_full_ov", d8_ov, 8'b1001_0001);
    #2 Resetn = 1'b0;
    #1;
    chk("mid_rst_ov8", d8_ov, 8'h00);
    chk("mid_rst_ov6", d6_ov, 6'h00);
    chk("mid_rst_drop6", d6_drop, 16'h0);
    chk("mid_rst_data8", d8_concat, 64'h0);
    tick();
    Resetn = 1'b1;
    tick();
    d8_sel = 3'd3; d8_data = 8'hA5; d8_valid = 1'b1;
    tick();
    d8_valid = 1'b0;
    chk("post_rst_ov", d8_ov, 8'b0000_1000);
    chk("post_rst_data", d8_concat, 64'h0000_0000_A500_0000);

    // Randomized traffic on the 6-channel instance against the model
    for (int k = 0; k < 6; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = 8'h00;
    end
    m_drop = 0;
    m_err  = 1'b0;
    for (int n = 0; n < 400; n++) begin
      d6_valid = ($urandom_range(0, 3) != 0);
      d6_sel   = 3'($urandom_range(0, 7));
      d6_data  = 8'($urandom);
      d6_or    = 6'($urandom);
      #1;
      sel = int'(d6_sel);
      exp_ready = (sel >= 6) ? 1'b1 : (!m_valid[sel] || d6_or[sel]);
      chk("rnd_ready", d6_in_ready, exp_ready);
      acc = d6_valid && exp_ready;
      for (int k = 0; k < 6; k++) begin
        if (m_valid[k] && d6_or[k]) m_valid[k] = 1'b0;
      end
      if (acc && sel < 6) begin
        m_valid[sel] = 1'b1;
        m_data[sel]  = d6_data;
      end
      m_err = acc && (sel >= 6);
      if (m_err && m_drop < 65535) m_drop++;
      tick();
      for (int k = 0; k < 6; k++) begin
        exp_ov[k]        = m_valid[k];
        exp_c[k*8 +: 8]  = m_data[k];
      end
      chk("rnd_ov", d6_ov, exp_ov);
      chk("rnd_data", d6_concat, exp_c);
      chk("rnd_err", d6_err, m_err);
      chk("rnd_drop", d6_drop, 16'(m_drop));
    end

    // DropCount saturation
    d6_or = '0;
    d6_sel = 3'd6; d6_valid = 1'b1;
    need = 65535 - m_drop;
    repeat (need) tick();
    chk("sat_reach", d6_drop, 16'hFFFF);
    d6_sel = 3'd7;
    repeat (2) tick();
    chk("sat_hold", d6_drop, 16'hFFFF);
    chk("sat_err", d6_err, 1'b1);
    d6_valid = 1'b0;
    tick();
    chk("sat_err_clear", d6_err, 1'b0);
    chk("sat_final", d6_drop, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
